// File: rtl/trace_pkg.sv
// Shared types and widths for the writeback trace buffer.
package trace_pkg;

  localparam int SEQ_W  = 8;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int WNUM_W = 5;
  localparam int WEN_W  = 4;

  // One retired register write, tagged with its capture sequence number.
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [PC_W-1:0]   pc;
    logic [WNUM_W-1:0] wnum;
    logic [DATA_W-1:0] wdata;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // A write is traced when any byte lane is enabled, and register 0 is
  // skipped only when zero filtering is on.
  function automatic logic is_capture(input logic [WEN_W-1:0]  wen,
                                      input logic [WNUM_W-1:0] wnum,
                                      input logic              filter_zero);
    return (wen != '0) && ((wnum != '0) || !filter_zero);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous show-ahead FIFO. Pointers carry an extra wrap bit so
// full and empty are told apart without a separate flag.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, cnt;
  logic             do_push, do_pop, flush;

  assign flush   = reset | clear;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Pops on an empty FIFO are ignored; a push into a full FIFO only lands
  // when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy tracking; flush wins over any handshake.
  always_ff @(posedge clk) begin
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no reset since reads are masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
  assign count = cnt;

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures retired register writes into a tagged trace FIFO. The CPU is never
// stalled: records that find the FIFO full are dropped and counted.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FILTER_ZERO = 1,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PC_W-1:0]         debug_wb_pc,
  input  logic [WEN_W-1:0]        debug_wb_rf_wen,
  input  logic [WNUM_W-1:0]       debug_wb_rf_wnum,
  input  logic [DATA_W-1:0]       debug_wb_rf_wdata,
  input  logic                    trace_clear,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [PC_W-1:0]         trace_pc,
  output logic [WNUM_W-1:0]       trace_wnum,
  output logic [DATA_W-1:0]       trace_wdata,
  output logic [$clog2(DEPTH):0]  trace_count,
  output logic                    trace_overflow,
  output logic [CNT_W-1:0]        trace_drops
);

  logic             cap, push, pop, drop, full, empty, flush;
  logic [SEQ_W-1:0] seq;
  trace_rec_t       wr_rec, hd_rec;

  assign flush = reset | trace_clear;
  assign cap   = is_capture(debug_wb_rf_wen, debug_wb_rf_wnum, FILTER_ZERO != 0);
  assign pop   = trace_valid & trace_ready;
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  assign wr_rec = '{seq:   seq,
                    pc:    debug_wb_pc,
                    wnum:  debug_wb_rf_wnum,
                    wdata: debug_wb_rf_wdata};

  // Sequence tag advances on every capture, stored or dropped, so gaps
  // reveal drops downstream.
  always_ff @(posedge clk) begin
    if (flush)    seq <= '0;
    else if (cap) seq <= seq + 1'b1;
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (flush) begin
      trace_overflow <= 1'b0;
      trace_drops    <= '0;
    end else if (drop) begin
      trace_overflow <= 1'b1;
      if (trace_drops != '1) trace_drops <= trace_drops + 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (trace_clear),
    .push  (push),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (hd_rec),
    .full  (full),
    .empty (empty),
    .count (trace_count)
  );

  assign trace_valid = ~empty;
  assign trace_seq   = hd_rec.seq;
  assign trace_pc    = hd_rec.pc;
  assign trace_wnum  = hd_rec.wnum;
  assign trace_wdata = hd_rec.wdata;

endmodule
